updown_sweep_ctrl: RTL and testbench

Sequencer that drives the shared 3-bit up/down counter through programmed triangle sweeps, lo -> hi -> lo, repeated N times.
- Accepts one sweep command through a valid/ready handshake.
- Drives the counter's load, enable and direction controls.
- Tracks a shadow position internally, so the counter output needs no feedback path.
- Reports completion, abort and bad-command status as 1-cycle pulses.

---
 rtl/updown_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// updown_sweep_ctrl: sequences a shared up/down counter through lo->hi->lo sweeps
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module updown_sweep_ctrl #(
  parameter int WIDTH = 3,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic [WIDTH-1:0] pos,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] pos_inc;
  logic [WIDTH-1:0] pos_dec;
  logic             bad_cmd;

  assign pos_inc = pos_q + WIDTH'(1);
  assign pos_dec = pos_q - WIDTH'(1);
  assign bad_cmd = (lo >= hi) || (reps == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      rep_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    rep_d   = rep_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // abort is deliberately not looked at here: a start wins over it
        if (start_valid) begin
          if (bad_cmd) begin
            err_d = 1'b1;
          end else begin
            lo_d    = lo;
            hi_d    = hi;
            rep_d   = reps;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          pos_d   = lo_q;
          state_d = S_UP;
        end
      end
      S_UP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          pos_d = pos_inc;
          if (pos_inc == hi_q) state_d = S_DOWN;
        end
      end
      S_DOWN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          pos_d = pos_dec;
          if (pos_dec == lo_q) begin
            rep_d   = rep_q - REP_W'(1);
            state_d = (rep_q == REP_W'(1)) ? S_DONE : S_UP;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign start_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign cnt_load     = (state_q == S_LOAD) && !abort;
  assign cnt_load_val = lo_q;
  assign cnt_en       = ((state_q == S_UP) || (state_q == S_DOWN)) && !abort;
  assign cnt_up       = (state_q == S_UP);
  assign pos          = pos_q;
  assign done         = (state_q == S_DONE);
  assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: directed table, hand-written corner sequences
// and randomized commands checked against a trace-building reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_updown_sweep_ctrl;

  localparam int WIDTH = 3;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] s_lo = '0;
  logic [WIDTH-1:0] s_hi = '0;
  logic [REP_W-1:0] s_reps = '0;
  logic             abort = 1'b0;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_up;
  logic [WIDTH-1:0] pos;
  logic             busy;
  logic             done;
  logic             err;

  updown_sweep_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .lo           (s_lo),
    .hi           (s_hi),
    .reps         (s_reps),
    .abort        (abort),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_en       (cnt_en),
    .cnt_up       (cnt_up),
    .pos          (pos),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] mpos = '0;

  // Observation vector: {load, en, up, busy, done, err, ready, pos[2:0]}
  function automatic logic [9:0] mk(bit ld, bit en, bit up, bit bz, bit dn,
                                    bit er, bit rdy, int p);
    logic [2:0] pp;
    pp = 3'(p);
    return {ld, en, up, bz, dn, er, rdy, pp};
  endfunction

  function automatic logic [9:0] act_vec();
    return {cnt_load, cnt_en, cnt_up, busy, done, err, start_ready, pos};
  endfunction

  task automatic check_vec(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = act_vec();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got {ld,en,up,busy,done,err,rdy,pos}=%b want %b",
               name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Enters and leaves at posedge+1. Issues one command, walks the expected
  // cycle trace derived from the sweep rules, and reports done latency/err.
  task automatic run_cmd(input int lo, input int hi, input int reps,
                         input int abort_at, input bit hold, input bit ab_start,
                         output int obs_lat, output bit obs_err);
    logic [9:0] tr[$];
    logic [9:0] e;
    bit bad, stopped;
    obs_lat = 0;
    obs_err = 1'b0;
    stopped = 1'b0;
    bad = (lo >= hi) || (reps == 0);
    start_valid = 1'b1;
    s_lo = 3'(lo);
    s_hi = 3'(hi);
    s_reps = 4'(reps);
    abort = ab_start;
    @(negedge clk);
    check_vec("accept_idle", mk(0, 0, 0, 0, 0, 0, 1, int'(mpos)));
    @(posedge clk); #1;
    abort = 1'b0;
    start_valid = hold && !bad;
    s_lo = 3'd0;
    s_hi = 3'd1;
    s_reps = 4'd1;
    if (bad) begin
      @(negedge clk);
      obs_err = err;
      check_vec("err_cycle", mk(0, 0, 0, 0, 0, 1, 1, int'(mpos)));
      @(posedge clk); #1;
      return;
    end
    tr.push_back(mk(1, 0, 0, 1, 0, 0, 0, int'(mpos)));
    for (int r = 0; r < reps; r++) begin
      for (int v = lo; v < hi; v++) tr.push_back(mk(0, 1, 1, 1, 0, 0, 0, v));
      for (int v = hi; v > lo; v--) tr.push_back(mk(0, 1, 0, 1, 0, 0, 0, v));
    end
    tr.push_back(mk(0, 0, 0, 1, 1, 0, 0, lo));
    for (int k = 0; k < tr.size(); k++) begin
      bit ab;
      ab = (k == abort_at) && (k < tr.size() - 1);
      abort = (k == abort_at);
      e = tr[k];
      if (ab) e = e & 10'b0011111111;
      @(negedge clk);
      if (done) obs_lat = k + 1;
      if (k == 0) obs_err = err;
      check_vec(ab ? "abort_cycle" : "trace", e);
      if (e[9]) check_int("load_val", int'(cnt_load_val), lo);
      @(posedge clk); #1;
      if (ab) begin
        mpos = tr[k][2:0];
        stopped = 1'b1;
        break;
      end
    end
    if (!stopped) mpos = 3'(lo);
    abort = 1'b0;
    start_valid = 1'b0;
  endtask

  typedef struct {
    int lo; int hi; int reps; int abort_at; bit hold;
    bit exp_err; int exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    bit er;
    // Reset state while rst is held low
    #2;
    @(negedge clk);
    check_vec("reset_state", mk(0, 0, 0, 0, 0, 0, 1, 0));
    check_int("reset_load_val", int'(cnt_load_val), 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{1, 4, 1, -1, 0, 0, 8});
    vecs.push_back('{0, 7, 2, -1, 0, 0, 30});
    vecs.push_back('{5, 3, 1, -1, 0, 1, 0});
    vecs.push_back('{3, 5, 0, -1, 0, 1, 0});
    vecs.push_back('{2, 2, 2, -1, 0, 1, 0});
    vecs.push_back('{2, 6, 3, -1, 1, 0, 26});
    vecs.push_back('{2, 6, 1, 4, 0, 0, 0});
    vecs.push_back('{0, 1, 1, -1, 0, 0, 4});
    vecs.push_back('{6, 7, 3, 7, 0, 0, 8});
    vecs.push_back('{0, 7, 1, -1, 0, 0, 16});
    vecs.push_back('{0, 7, 1, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      run_cmd(vecs[i].lo, vecs[i].hi, vecs[i].reps, vecs[i].abort_at,
              vecs[i].hold, 1'b0, lat, er);
      check_int($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check_int($sformatf("vec%0d_err", i), int'(er), int'(vecs[i].exp_err));
    end

    // Start and abort together in IDLE: start wins
    run_cmd(1, 3, 1, -1, 0, 1'b1, lat, er);
    check_int("abort_with_start_latency", lat, 6);

    // Asynchronous reset in the middle of a DOWN phase
    start_valid = 1'b1; s_lo = 3'd2; s_hi = 3'd6; s_reps = 4'd1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_vec("pre_reset_down", mk(0, 1, 0, 1, 0, 0, 0, 5));
    #2 rst = 1'b0;
    #1;
    check_vec("async_reset", mk(0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk); #1;
    rst = 1'b1;
    mpos = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check_vec("post_reset_idle", mk(0, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;

    // Randomized commands against the trace model
    for (int n = 0; n < 40; n++) begin
      int lo, hi, reps, len, ab_at, exp_lat;
      bit bad;
      lo = $urandom_range(0, 7);
      hi = $urandom_range(0, 7);
      reps = $urandom_range(0, 3);
      bad = (lo >= hi) || (reps == 0);
      len = bad ? 1 : 2 + 2 * (hi - lo) * reps;
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      exp_lat = (bad || (ab_at >= 0 && ab_at < len - 1)) ? 0 : len;
      run_cmd(lo, hi, reps, ab_at, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), lat, er);
      check_int($sformatf("rand%0d_latency", n), lat, exp_lat);
      check_int($sformatf("rand%0d_err", n), int'(er), int'(bad));
    end

    @(negedge clk);
    check_vec("final_idle", mk(0, 0, 0, 0, 0, 0, 1, int'(mpos)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
